// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx : I2S receiver, oversampled in the audio clock domain.
//
// Reassembles 32-bit LSB-first words from sclk/wclk/sdata and hands them out
// over a valid/ready interface. Bits [15:0] travel while wclk is low and bits
// [31:16] while wclk is high. Data is delayed one bit after each wclk edge.
//
// Ports
//   aud_clk_i      in   audio clock, sole clock
//   aud_rst_i      in   synchronous active-high reset
//   sclk_i         in   serial bit clock (period >= 8 aud_clk_i cycles)
//   wclk_i         in   word clock (falling edge marks a frame boundary)
//   sdata_i        in   serial data
//   audio_data_o   out  received word, bit 0 = first bit of frame
//   audio_valid_o  out  audio_data_o holds an unconsumed word
//   audio_ready_i  in   downstream accepts the word when high with valid
//   overrun_o      out  sticky: a completed word was dropped (output full)
//   frame_err_o    out  sticky: frame boundary with bit count != 32
// ---------------------------------------------------------------------------
module i2s_rx #(
    parameter int SYNC_STAGES = 2,
    parameter bit DROP_FIRST  = 1'b1
) (
    input  logic        aud_clk_i,
    input  logic        aud_rst_i,
    input  logic        sclk_i,
    input  logic        wclk_i,
    input  logic        sdata_i,
    output logic [31:0] audio_data_o,
    output logic        audio_valid_o,
    input  logic        audio_ready_i,
    output logic        overrun_o,
    output logic        frame_err_o
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] wclk_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;

    logic        sclk_s;
    logic        wclk_s;
    logic        sdata_s;
    logic        sclk_d;
    logic        wclk_d;
    logic        bnd;
    logic        first;
    logic [31:0] shift;
    logic [5:0]  cnt;

    logic        sclk_rise;
    logic        wclk_fall;
    logic        complete;
    logic [5:0]  cnt_next;
    logic        len_ok;
    logic        emit;
    logic        err;
    logic [31:0] word;

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign wclk_s  = wclk_sync[SYNC_STAGES-1];
    assign sdata_s = sdata_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign wclk_fall = ~wclk_s & wclk_d;

    // A wclk fall coinciding with an sclk rise completes the word on that rise.
    assign complete = sclk_rise & (bnd | wclk_fall);

    // Saturating count of the rise being taken now; the completing rise
    // carries bit 31 of the previous frame, so a good frame lands on 32.
    assign cnt_next = (cnt == 6'd63) ? cnt : cnt + 6'd1;
    assign len_ok   = (cnt_next == 6'd32);
    assign word     = {sdata_s, shift[31:1]};

    assign emit = complete & len_ok & (~first | ~DROP_FIRST);
    assign err  = complete & ~len_ok & ~first;

    always_ff @(posedge aud_clk_i) begin
        if (aud_rst_i) begin
            sclk_sync     <= '0;
            wclk_sync     <= '0;
            sdata_sync    <= '0;
            sclk_d        <= 1'b0;
            wclk_d        <= 1'b0;
            bnd           <= 1'b0;
            first         <= 1'b1;
            shift         <= '0;
            cnt           <= '0;
            audio_data_o  <= '0;
            audio_valid_o <= 1'b0;
            overrun_o     <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            // Identical chains keep the three lines aligned to each other.
            sclk_sync[0]  <= sclk_i;
            wclk_sync[0]  <= wclk_i;
            sdata_sync[0] <= sdata_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i]  <= sclk_sync[i-1];
                wclk_sync[i]  <= wclk_sync[i-1];
                sdata_sync[i] <= sdata_sync[i-1];
            end
            sclk_d <= sclk_s;
            wclk_d <= wclk_s;

            if (sclk_rise) begin
                bnd <= 1'b0;
            end else if (wclk_fall) begin
                bnd <= 1'b1;
            end

            if (sclk_rise) begin
                shift <= word;
                cnt   <= complete ? 6'd0 : cnt_next;
            end

            if (complete) begin
                first <= 1'b0;
            end

            if (err) begin
                frame_err_o <= 1'b1;
            end

            if (emit) begin
                if (!audio_valid_o || audio_ready_i) begin
                    audio_data_o  <= word;
                    audio_valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (audio_valid_o && audio_ready_i) begin
                audio_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx : directed bench for i2s_rx with a behavioural I2S transmitter.
// Expected words go into a queue as frames are sent; a monitor pops and
// compares on every handshake.
// ---------------------------------------------------------------------------
module tb_i2s_rx;

    logic        aud_clk_i = 1'b0;
    logic        aud_rst_i = 1'b1;
    logic        sclk_i    = 1'b0;
    logic        wclk_i    = 1'b0;
    logic        sdata_i   = 1'b0;
    logic        audio_ready_i = 1'b1;
    logic [31:0] audio_data_o;
    logic        audio_valid_o;
    logic        overrun_o;
    logic        frame_err_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          ready_mode = 0;   // 0: hold 1, 1: hold 0, 2: toggle
    logic        prev_bit = 1'b0;
    logic [31:0] last_rx  = '0;
    logic [31:0] exp_q [$];
    int          acc_t [$];

    i2s_rx #(.SYNC_STAGES(2), .DROP_FIRST(1'b1)) dut (
        .aud_clk_i     (aud_clk_i),
        .aud_rst_i     (aud_rst_i),
        .sclk_i        (sclk_i),
        .wclk_i        (wclk_i),
        .sdata_i       (sdata_i),
        .audio_data_o  (audio_data_o),
        .audio_valid_o (audio_valid_o),
        .audio_ready_i (audio_ready_i),
        .overrun_o     (overrun_o),
        .frame_err_o   (frame_err_o)
    );

    always #5 aud_clk_i = ~aud_clk_i;

    always @(posedge aud_clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Ready driver: changes just after each active edge.
    initial begin
        forever begin
            @(posedge aud_clk_i);
            #1;
            case (ready_mode)
                0:       audio_ready_i = 1'b1;
                1:       audio_ready_i = 1'b0;
                default: audio_ready_i = ~audio_ready_i;
            endcase
        end
    end

    // Scoreboard monitor: a word is consumed at the next edge when valid&ready.
    initial begin
        forever begin
            @(negedge aud_clk_i);
            if (!aud_rst_i && audio_valid_o && audio_ready_i) begin
                acc_t.push_back(cyc);
                last_rx = audio_data_o;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", audio_data_o, 32'hxxxx_xxxx);
                end else begin
                    check("rx_word", audio_data_o, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge aud_clk_i);
        aud_rst_i = 1'b1;
        sclk_i    = 1'b0;
        wclk_i    = 1'b0;
        sdata_i   = 1'b0;
        prev_bit  = 1'b0;
        repeat (4) @(negedge aud_clk_i);
        aud_rst_i = 1'b0;
        repeat (4) @(negedge aud_clk_i);
    endtask

    // One frame: each slot starts with an sclk fall carrying the previous bit
    // (one-bit delay). nrise < 32 suppresses the sclk pulse of the last slot.
    task automatic send_frame(input logic [31:0] w, input int nrise, input int half,
                              input int rst_at, input int rdy_at);
        for (int j = 0; j < 32; j++) begin
            @(negedge aud_clk_i);
            sclk_i  = (j == 31 && nrise < 32) ? 1'b1 : 1'b0;
            wclk_i  = (j >= 16);
            sdata_i = prev_bit;
            if (j == rdy_at) ready_mode = 0;
            if (j == rst_at) begin
                aud_rst_i = 1'b1;
                repeat (3) @(negedge aud_clk_i);
                check("rst_data",    audio_data_o,  32'h0);
                check("rst_valid",   {31'b0, audio_valid_o}, 32'h0);
                check("rst_overrun", {31'b0, overrun_o},     32'h0);
                check("rst_ferr",    {31'b0, frame_err_o},   32'h0);
                aud_rst_i = 1'b0;
                repeat (half - 3) @(negedge aud_clk_i);
            end else begin
                repeat (half) @(negedge aud_clk_i);
            end
            sclk_i   = 1'b1;
            prev_bit = w[j];
            repeat (half - 1) @(negedge aud_clk_i);
        end
    endtask

    // Final boundary slot so the last frame completes, then idle.
    task automatic flush(input int half);
        @(negedge aud_clk_i);
        sclk_i  = 1'b0;
        wclk_i  = 1'b0;
        sdata_i = prev_bit;
        repeat (half) @(negedge aud_clk_i);
        sclk_i = 1'b1;
        repeat (40) @(negedge aud_clk_i);
    endtask

    initial begin
        do_reset();
        check("reset_data",  audio_data_o, 32'h0);
        check("reset_flags", {29'b0, audio_valid_o, overrun_o, frame_err_o}, 32'h0);

        // Loopback: dummy first frame is discarded, then three words.
        acc_t.delete();
        send_frame(32'h5555_5555, 32, 8, -1, -1);
        exp_q.push_back(32'h1234_ABCD); send_frame(32'h1234_ABCD, 32, 8, -1, -1);
        exp_q.push_back(32'hDEAD_BEEF); send_frame(32'hDEAD_BEEF, 32, 8, -1, -1);
        exp_q.push_back(32'h0000_0001); send_frame(32'h0000_0001, 32, 8, -1, -1);
        flush(8);
        check("lb_count",   acc_t.size(), 3);
        if (acc_t.size() == 3) begin
            check("lb_space0", acc_t[1] - acc_t[0], 512);
            check("lb_space1", acc_t[2] - acc_t[1], 512);
        end
        check("lb_flags", {30'b0, overrun_o, frame_err_o}, 32'h0);
        check("lb_q_empty", exp_q.size(), 0);

        // Overrun: ready low for 3 frames after A5A5_5A5A, then the word on
        // the wire is next; continues straight into the mid-frame reset.
        do_reset();
        ready_mode = 1;
        send_frame(32'h0BAD_F00D, 32, 8, -1, -1);
        exp_q.push_back(32'hA5A5_5A5A); send_frame(32'hA5A5_5A5A, 32, 8, -1, -1);
        send_frame(32'h1111_1111, 32, 8, -1, -1);
        send_frame(32'h2222_2222, 32, 8, -1, -1);
        send_frame(32'h3333_3333, 32, 8, -1, -1);
        check("ovr_data_held", audio_data_o, 32'hA5A5_5A5A);
        check("ovr_valid",     {31'b0, audio_valid_o}, 32'h1);
        check("ovr_flag",      {31'b0, overrun_o},     32'h1);
        exp_q.push_back(32'h4444_4444); send_frame(32'h4444_4444, 32, 8, -1, 8);

        // Reset at bit 10: partial frame dropped, following frames emitted.
        send_frame(32'h7777_7777, 32, 8, 10, -1);
        exp_q.push_back(32'h0F0F_1234); send_frame(32'h0F0F_1234, 32, 8, -1, -1);
        exp_q.push_back(32'hCAFE_0042); send_frame(32'hCAFE_0042, 32, 8, -1, -1);
        flush(8);
        check("rst_post_flags", {30'b0, overrun_o, frame_err_o}, 32'h0);
        check("ovr_q_empty", exp_q.size(), 0);

        // Corrupt frame: 31 rises -> frame error, next frame still received.
        do_reset();
        send_frame(32'h9999_9999, 32, 8, -1, -1);
        send_frame(32'hBBBB_BBBB, 31, 8, -1, -1);
        exp_q.push_back(32'h8000_0000); send_frame(32'h8000_0000, 32, 8, -1, -1);
        flush(8);
        check("cor_ferr",    {31'b0, frame_err_o}, 32'h1);
        check("cor_overrun", {31'b0, overrun_o},   32'h0);
        check("cor_q_empty", exp_q.size(), 0);

        // Fast sclk: period 8 cycles.
        do_reset();
        send_frame(32'h0000_FFFF, 32, 4, -1, -1);
        exp_q.push_back(32'hFFFF_0000); send_frame(32'hFFFF_0000, 32, 4, -1, -1);
        flush(4);
        check("fast_low_half",  {16'b0, last_rx[15:0]},  32'h0);
        check("fast_high_half", {16'b0, last_rx[31:16]}, 32'h0000_FFFF);
        check("fast_q_empty", exp_q.size(), 0);

        // Ready toggling every cycle while frames stream.
        do_reset();
        ready_mode = 2;
        send_frame(32'h0, 32, 8, -1, -1);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] w;
            w = $urandom();
            exp_q.push_back(w);
            send_frame(w, 32, 8, -1, -1);
        end
        flush(8);
        repeat (4) @(negedge aud_clk_i);
        ready_mode = 0;
        check("tog_overrun", {31'b0, overrun_o},   32'h0);
        check("tog_ferr",    {31'b0, frame_err_o}, 32'h0);
        check("tog_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
